serial_addsub: RTL
==================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter WIDTH, default 8, SHALL set the operand/result width in bits.
REQ-003 Parameter DIGIT, default 2, SHALL set bits processed per cycle; WIDTH mod DIGIT SHALL be 0 and DIGIT ≥ 1.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RESETN  input  1  asynchronous active-low reset.
REQ-006 I0  input  WIDTH  minuend/addend A.
REQ-007 I1  input  WIDTH  subtrahend/addend B.
REQ-008 SUB  input  1  mode select: 0 = A+B, 1 = A-B.
REQ-009 IN_VALID  input  1  operands and SUB are valid.
REQ-010 IN_READY  output  1  block can accept operands.
REQ-011 O  output  WIDTH  result.
REQ-012 COUT  output  1  final carry out; in subtract mode 1 = no borrow.
REQ-013 V  output  1  two's-complement signed overflow.
REQ-014 OUT_VALID  output  1  O, COUT and V are valid.
REQ-015 OUT_READY  input  1  consumer accepts the result.

Function
REQ-016 States SHALL be IDLE, RUN and DONE.
REQ-017 IN_READY SHALL be 1 only in IDLE; OUT_VALID SHALL be 1 only in DONE.
REQ-018 Accept: in IDLE with IN_VALID=1, the edge SHALL latch I0, I1 and SUB, set carry=SUB and digit counter=0, and enter RUN.
REQ-019 Subtraction SHALL be computed as A + ~B + 1 (the carry-in is the latched SUB); addition as A + B + 0.
REQ-020 Each RUN cycle SHALL add digit k (bits k*DIGIT..k*DIGIT+DIGIT-1) with the registered carry, store the digit sum, register the carry out and increment k.
REQ-021 After digit WIDTH/DIGIT-1 the block SHALL enter DONE, so OUT_VALID rises exactly WIDTH/DIGIT cycles after the accept edge.
REQ-022 On entry to DONE, O SHALL equal (A ± B) mod 2^WIDTH.
REQ-023 On entry to DONE, COUT SHALL equal the carry out of bit WIDTH-1.
REQ-024 On entry to DONE, V SHALL equal (carry into bit WIDTH-1) XOR COUT.
REQ-025 O, COUT and V SHALL change only on entry to DONE or on reset, and SHALL hold stable through RUN and IDLE.
REQ-026 In DONE with OUT_READY=0, all outputs SHALL hold.
REQ-027 In DONE with OUT_READY=1, the block SHALL return to IDLE at the next edge; there is no DONE-to-RUN bypass, so back-to-back throughput is one op per WIDTH/DIGIT+2 cycles.
REQ-028 IN_VALID and operand changes outside IDLE SHALL be ignored.
REQ-029 Operand changes after the accept edge SHALL NOT affect the result.
REQ-030 DIGIT=WIDTH SHALL be legal and give a single RUN cycle.

Reset
REQ-031 RESETN=0 SHALL immediately force state IDLE, counter 0, carry 0, O=0, COUT=0, V=0, OUT_VALID=0 and IN_READY=1, independent of CLK.
REQ-032 Reset asserted mid-RUN or in DONE SHALL discard the operation in progress with no result emitted.
REQ-033 The first accept SHALL be possible on the first rising edge after RESETN deasserts.

Configuration
REQ-034 With SERIAL_ADDSUB_SAT_EN defined and V=1 on entry to DONE, O SHALL saturate: 2^(WIDTH-1)-1 if latched A[WIDTH-1]=0, else 2^(WIDTH-1).
REQ-035 With SERIAL_ADDSUB_SAT_EN defined, V and COUT SHALL still report the raw unsaturated values.
REQ-036 Without SERIAL_ADDSUB_SAT_EN, O SHALL wrap modulo 2^WIDTH and no saturation logic SHALL be present.

Verification (WIDTH=8, DIGIT=2)
REQ-037 Add: accept 0x05+0x03, SUB=0 -> OUT_VALID exactly 4 cycles after accept, O=0x08, COUT=0, V=0.
REQ-038 Subtract: 0x03-0x05 -> O=0xFE, COUT=0, V=0; and 0x05-0x03 -> O=0x02, COUT=1, V=0.
REQ-039 Overflow: 0x7F+0x01 -> V=1, COUT=0, O=0x80 (0x7F with SAT_EN); 0x80-0x01 -> V=1, COUT=1, O=0x7F (0x80 with SAT_EN).
REQ-040 Backpressure: hold OUT_READY=0 for 3 cycles in DONE while toggling IN_VALID and operands -> outputs stable, IN_READY=0, no new accept; OUT_READY=1 -> IDLE next edge.
REQ-041 Reset mid-RUN: assert RESETN=0 at k=2 -> all outputs 0 immediately, IN_READY=1; the next op 0x10+0x20 yields 0x30.
REQ-042 Random: 1000 random ops, both modes, DIGIT in {1,2,4,8} -> O, COUT and V match the reference model.

Source files
------------

// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial two's-complement adder/subtractor that
// processes DIGIT bits per cycle behind valid/ready handshakes.
//
// Parameters:
//   WIDTH     operand/result width in bits (default 8)
//   DIGIT     bits processed per RUN cycle; must divide WIDTH (default 2)
// Ports:
//   CLK        rising-edge clock
//   RESETN     asynchronous active-low reset
//   I0, I1     operands A and B, sampled on the accept edge
//   SUB        0 = A+B, 1 = A-B, sampled on the accept edge
//   IN_VALID   operands and SUB are valid
//   IN_READY   high only while idle (ready to accept)
//   O          result
//   COUT       carry out of the MSB (subtract: 1 = no borrow)
//   V          signed overflow
//   OUT_VALID  O/COUT/V valid, held until OUT_READY
//   OUT_READY  consumer takes the result
// Configuration:
//   SERIAL_ADDSUB_SAT_EN  when defined, O saturates on signed overflow
//                         (COUT and V keep their raw values).
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             SUB,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] O,
    output logic             COUT,
    output logic             V,
    output logic             OUT_VALID,
    input  logic             OUT_READY
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;

    // B is stored already inverted for subtraction, so the datapath
    // is always a plain add with carry-in = latched SUB.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    k;

    logic [IW-1:0]    base;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] dsum;
    logic [DIGIT:0]   c;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] o_next;
    logic             v_next;

    // One digit of ripple addition per cycle.
    always_comb begin
        base  = IW'(int'(k) * DIGIT);
        a_dig = a_q[base +: DIGIT];
        b_dig = b_q[base +: DIGIT];
        dsum  = '0;
        c     = '0;
        c[0]  = carry;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]  = a_dig[i] ^ b_dig[i] ^ c[i];
            c[i + 1] = (a_dig[i] & b_dig[i]) |
                       (c[i] & (a_dig[i] ^ b_dig[i]));
        end
        res = acc;
        res[base +: DIGIT] = dsum;
        // On the last digit, c[DIGIT-1] is the carry into the MSB.
        v_next = c[DIGIT - 1] ^ c[DIGIT];
    end

`ifdef SERIAL_ADDSUB_SAT_EN
    logic [WIDTH-1:0] sat_val;

    // Clamp toward the sign of A: positive overflow only happens
    // with A non-negative, negative overflow only with A negative.
    always_comb begin
        sat_val = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
        o_next  = v_next ? sat_val : res;
    end
`else
    assign o_next = res;
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            k         <= '0;
            O         <= '0;
            COUT      <= 1'b0;
            V         <= 1'b0;
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        a_q      <= I0;
                        b_q      <= SUB ? ~I1 : I1;
                        carry    <= SUB;
                        k        <= '0;
                        IN_READY <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc   <= res;
                    carry <= c[DIGIT];
                    if (k == LAST) begin
                        k         <= '0;
                        O         <= o_next;
                        COUT      <= c[DIGIT];
                        V         <= v_next;
                        OUT_VALID <= 1'b1;
                        state     <= DONE;
                    end else begin
                        k <= k + CW'(1);
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        IN_READY  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    OUT_VALID <= 1'b0;
                    IN_READY  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
